mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between two requesters of the multicycle RISC-V datapath: the instruction-fetch port (IF) and the load/store data port (D).
- Sits between the control-unit-driven datapath and the memory.
- Serialises requests and inserts the fixed memory read latency.
- Returns a one-cycle acknowledge with registered read data, so the control unit can replace fixed wait states (e.g. its post-read state) with an ack-driven handshake.

Parameters:
- MEM_LAT, 1, memory read latency in cycles after the issue cycle; legal range 1..15.
- STARVE_MAX, 3, maximum consecutive D grants while IF is waiting before IF is forced to win; legal range 1..15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- if_req  in  1  instruction-fetch request; level, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle pulse: fetch complete.
- if_rdata  out  DATA_W  fetched word; valid in the if_ack cycle and held until the next IF completion.
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_tam  in  2  access size: 00 word, 01 half, 10 byte (same encoding as the control unit's tam).
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DATA_W  load data; valid in the d_ack cycle and held until the next D load completion.
- mem_en  out  1  memory access strobe; high only in the ISSUE cycle.
- mem_we  out  1  memory write strobe; high only in the ISSUE cycle of a store.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered write data.
- mem_tam  out  2  registered access size.
- mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after the ISSUE cycle.
- busy  out  1  high whenever state != IDLE.
- owner  out  1  0 = IF, 1 = D; the current or last granted requester.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: every output 0; state IDLE; starve counter 0; wait counter 0.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: remain in IDLE.
  - A request present at a clock edge: select the winner, latch its addr/wdata/we/tam into the mem_* registers, set owner, and go to ISSUE.
  - An IF grant always drives mem_we=0 and mem_tam=00.
- Arbitration: D has priority over IF, except when the starve counter equals STARVE_MAX and if_req=1; then IF wins.
- Starve counter:
  - Increments on a D grant made while if_req=1.
  - Clears on any IF grant.
  - Clears on a D grant made while if_req=0.
  - Saturates at STARVE_MAX.
- ISSUE (1 cycle): mem_en=1; mem_we=1 if the latched access is a store. Load the wait counter with MEM_LAT-1, then go to WAIT.
- WAIT (MEM_LAT cycles): mem_en=0 and mem_we=0. Decrement the counter each cycle.
  - On the cycle the counter is 0, at the clock edge: capture mem_rdata into if_rdata or d_rdata (owner's port, loads and fetches only), then go to DONE.
  - Stores do not update d_rdata.
- DONE (1 cycle): the owner's ack=1, then go to IDLE.
  - Requests seen during DONE are not granted.
  - The owner may still hold req high in its ack cycle; this must not create a second grant.
  - The next grant decision is taken in IDLE.
- Timing: req first high in cycle 0 (arbiter IDLE) gives ISSUE in cycle 1, WAIT in cycles 2..MEM_LAT+1, and ack in cycle MEM_LAT+2.
- Minimum spacing between consecutive ISSUE cycles is MEM_LAT+3.
- mem_addr, mem_wdata and mem_tam are stable from ISSUE through DONE and hold their last values in IDLE.
- Withdrawing req after a grant does not abort the transaction; it completes and acks.
- The losing requester waits with req high; its request is neither lost nor duplicated.
- Reset mid-transaction: immediate return to IDLE with all outputs 0; the in-flight access is dropped and no ack is issued.

Test Plan:
- MEM_LAT=1, IF read from 0x100 only, memory returning 0xDEADBEEF → mem_en high in cycle 1, if_ack in cycle 3, if_rdata=0xDEADBEEF, busy high in cycles 1-3.
- d_req and if_req both raised in cycle 0 → D granted first (owner=1, d_ack in cycle 3), then IF ISSUE in cycle 5 with if_ack in cycle 7; exactly one ack each.
- STARVE_MAX=3, d_req held continuously with if_req high → grant order D,D,D,IF,D,D,D,IF; starve counter returns to 0 after each IF grant.
- Store d_addr=0x40, d_wdata=0x12345678, d_tam=10 → mem_we=1 for exactly one cycle with mem_tam=10; d_rdata unchanged; d_ack in cycle MEM_LAT+2.
- MEM_LAT=4 load → WAIT lasts 4 cycles, mem_rdata sampled in the last WAIT cycle, d_ack in cycle 6.
- Reset asserted in the WAIT cycle → all outputs 0 in the same cycle, no ack ever; a fresh if_req after reset completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the instruction-fetch (IF) and
// load/store (D) ports of the multicycle datapath; inserts the read latency and acks.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_tam,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_tam,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] starve_q;
    logic             we_q;

    logic             starved_c;
    logic             d_win_c;

    // IF overrides D priority only once D has won STARVE_MAX times in a row over a waiting IF
    assign starved_c = if_req && (starve_q == CNT_W'(STARVE_MAX));
    assign d_win_c   = d_req && !starved_c;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            starve_q  <= '0;
            we_q      <= 1'b0;
            if_ack    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_tam   <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        state_q <= ISSUE;
                        busy    <= 1'b1;
                        mem_en  <= 1'b1;
                        if (d_win_c) begin
                            owner     <= 1'b1;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_tam   <= d_tam;
                            mem_we    <= d_we;
                            we_q      <= d_we;
                            if (!if_req) begin
                                starve_q <= '0;
                            end else if (starve_q < CNT_W'(STARVE_MAX)) begin
                                starve_q <= starve_q + CNT_W'(1);
                            end
                        end else begin
                            owner    <= 1'b0;
                            mem_addr <= if_addr;
                            mem_tam  <= 2'b00;
                            we_q     <= 1'b0;
                            starve_q <= '0;
                        end
                    end
                end

                ISSUE: begin
                    wait_q  <= CNT_W'(MEM_LAT - 1);
                    state_q <= WAIT;
                end

                // Read data is valid in the last WAIT cycle; capture it on the way out
                WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= DONE;
                        if (owner) begin
                            d_ack <= 1'b1;
                            if (!we_q) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        wait_q <= wait_q - CNT_W'(1);
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
